pkt_ingress_arbiter: RTL



---
 rtl/pkt_ingress_arbiter_pkg.sv | 22 ++
 rtl/pkt_ingress_arbiter_fifo.sv | 100 ++++++++++
 rtl/pkt_ingress_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pkt_ingress_arbiter_pkg.sv
// Shared word format and arbiter state encoding for the packet ingress arbiter.
// Word layout: [133:132] tag, [131:128] valid-byte info, [127:0] data.
package pkt_ingress_arbiter_pkg;

   localparam int unsigned PKT_WIDTH = 134;
   localparam int unsigned TAG_MSB   = 133;
   localparam int unsigned TAG_LSB   = 132;

   localparam logic [1:0] TAG_HEAD = 2'b01;
   localparam logic [1:0] TAG_TAIL = 2'b10;
   localparam logic [1:0] TAG_BODY = 2'b00;

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } arb_state_t;

   function automatic logic [1:0] pkt_tag(input logic [PKT_WIDTH-1:0] word);
      return word[TAG_MSB:TAG_LSB];
   endfunction

endpackage

// File: rtl/pkt_ingress_arbiter_fifo.sv
// Packet-aware per-port FIFO: admits whole packets only, rewinds partial or
// oversize packets, and exposes a completed-packet count to the arbiter.
module pkt_port_fifo
   import pkt_ingress_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned MAX_WORDS = 96
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_valid,
   input  logic [PKT_WIDTH-1:0] wr_data,
   input  logic                 rd_en,
   input  logic                 rd_last,
   output logic [PKT_WIDTH-1:0] rd_data,
   output logic                 pkt_avail,
   output logic                 drop
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(MAX_WORDS + 1);

   logic [PKT_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]          wr_ptr, rd_ptr, start_ptr, base_ptr, wr_addr, pkt_cnt;
   logic [AW+1:0]        free_words;
   logic [LW-1:0]        len;
   logic                 open_pkt, is_head, is_tail, wr_en, tail_done, drop_now;

   // A head arriving mid-packet reuses the open packet's start slot.
   always_comb begin
      base_ptr   = open_pkt ? start_ptr : wr_ptr;
      free_words = (AW+2)'(DEPTH) - {1'b0, base_ptr - rd_ptr};
      is_head    = pkt_tag(wr_data) == TAG_HEAD;
      is_tail    = pkt_tag(wr_data) == TAG_TAIL;
      wr_en      = 1'b0;
      tail_done  = 1'b0;
      drop_now   = 1'b0;
      if (wr_valid) begin
         if (is_head) begin
            drop_now = open_pkt;
            if (free_words >= (AW+2)'(MAX_WORDS)) wr_en = 1'b1;
            else                                 drop_now = 1'b1;
         end else if (open_pkt) begin
            if (len == LW'(MAX_WORDS)) begin
               drop_now = 1'b1;
            end else begin
               wr_en     = 1'b1;
               tail_done = is_tail;
            end
         end
      end
      wr_addr = is_head ? base_ptr : wr_ptr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         start_ptr <= '0;
         len       <= '0;
         open_pkt  <= 1'b0;
         pkt_cnt   <= '0;
         drop      <= 1'b0;
      end else begin
         if (wr_valid) begin
            if (is_head) begin
               start_ptr <= base_ptr;
               if (wr_en) begin
                  wr_ptr   <= base_ptr + 1'b1;
                  open_pkt <= 1'b1;
                  len      <= LW'(1);
               end else begin
                  wr_ptr   <= base_ptr;
                  open_pkt <= 1'b0;
               end
            end else if (open_pkt) begin
               if (drop_now) begin
                  wr_ptr   <= start_ptr;
                  open_pkt <= 1'b0;
               end else begin
                  wr_ptr <= wr_ptr + 1'b1;
                  len    <= len + 1'b1;
                  if (is_tail) open_pkt <= 1'b0;
               end
            end
         end
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         pkt_cnt <= pkt_cnt + (AW+1)'(tail_done) - (AW+1)'(rd_en & rd_last);
         drop    <= drop_now;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr[AW-1:0]] <= wr_data;
   end

   assign rd_data   = mem[rd_ptr[AW-1:0]];
   assign pkt_avail = pkt_cnt != '0;

endmodule

// File: rtl/pkt_ingress_arbiter.sv
// Packet-granular round-robin ingress arbiter over NUM_PORTS packet FIFOs.
// Define ARB_DROP_CNT_EN to add per-port saturating drop counters (o_drop_cnt).
module pkt_ingress_arbiter
   import pkt_ingress_arbiter_pkg::*;
#(
   parameter int unsigned NUM_PORTS     = 4,
   parameter int unsigned FIFO_DEPTH    = 256,
   parameter int unsigned MAX_PKT_WORDS = 96
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [NUM_PORTS-1:0]           i_pkt_valid,
   input  logic [NUM_PORTS*PKT_WIDTH-1:0] i_pkt,
   output logic                           o_pkt_valid,
   output logic [PKT_WIDTH-1:0]           o_pkt,
   output logic [7:0]                     o_inport
`ifdef ARB_DROP_CNT_EN
   ,
   output logic [NUM_PORTS*16-1:0]        o_drop_cnt
`endif
);

   localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [PKT_WIDTH-1:0] rd_data [NUM_PORTS];
   logic [NUM_PORTS-1:0] pkt_avail, drop, rd_en, rd_last;
   logic [PKT_WIDTH-1:0] send_word;
   logic                 send_last, found;
   logic [PW-1:0]        rr_ptr, grant, next_grant;
   logic [PW:0]          idx;
   arb_state_t           state;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      pkt_port_fifo #(
         .DEPTH     (FIFO_DEPTH),
         .MAX_WORDS (MAX_PKT_WORDS)
      ) u_fifo (
         .clk       (i_clk),
         .rst_n     (i_rst_n),
         .wr_valid  (i_pkt_valid[p]),
         .wr_data   (i_pkt[PKT_WIDTH*p +: PKT_WIDTH]),
         .rd_en     (rd_en[p]),
         .rd_last   (rd_last[p]),
         .rd_data   (rd_data[p]),
         .pkt_avail (pkt_avail[p]),
         .drop      (drop[p])
      );
   end

   // First port with a complete packet, scanning from rr_ptr with wrap.
   always_comb begin
      found      = 1'b0;
      next_grant = rr_ptr;
      idx        = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         idx = {1'b0, rr_ptr} + (PW+1)'(i);
         if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
         if (!found && pkt_avail[idx[PW-1:0]]) begin
            found      = 1'b1;
            next_grant = idx[PW-1:0];
         end
      end
   end

   always_comb begin
      rd_en     = '0;
      rd_last   = '0;
      send_word = rd_data[grant];
      send_last = pkt_tag(send_word) == TAG_TAIL;
      if (state == ST_SEND) begin
         rd_en[grant]   = 1'b1;
         rd_last[grant] = send_last;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         grant       <= '0;
         o_pkt_valid <= 1'b0;
         o_pkt       <= '0;
         o_inport    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               o_pkt_valid <= 1'b0;
               if (found) begin
                  grant    <= next_grant;
                  rr_ptr   <= (next_grant == PW'(NUM_PORTS - 1)) ? '0 : next_grant + 1'b1;
                  o_inport <= 8'(next_grant);
                  state    <= ST_SEND;
               end
            end
            ST_SEND: begin
               o_pkt_valid <= 1'b1;
               o_pkt       <= send_word;
               if (send_last) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ARB_DROP_CNT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_drop_cnt <= '0;
      end else begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (drop[p] && o_drop_cnt[16*p +: 16] != 16'hFFFF)
               o_drop_cnt[16*p +: 16] <= o_drop_cnt[16*p +: 16] + 16'd1;
         end
      end
   end
`else
   logic unused_drop;
   assign unused_drop = ^drop;
`endif

endmodule
